// File: rtl/risc_fetch.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time from imem
// and hands it to decode; branch/jump redirects come from the immediate path.
module risc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic        redirect_is_jalr,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] redirect_imm,
    input  logic [31:0] redirect_rs1,
    output logic        misalign_err,
    output logic [31:0] fault_addr
);

    // state | meaning
    // IDLE  | one settling cycle after reset
    // REQ   | request at PC presented to imem
    // WAIT  | request accepted, waiting for rvalid
    // VALID | instruction held for decode
    // HALT  | misaligned redirect target; wait for aligned redirect
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_VALID,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        drop_q, drop_d;
    logic        err_q, err_d;
    logic [31:0] fault_q, fault_d;

    logic [31:0] redirect_target;
    logic        req;
    logic        accepted;
    logic        pending_after;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            inst_q   <= NOP_INST;
            pc_out_q <= RESET_PC;
            drop_q   <= 1'b0;
            err_q    <= 1'b0;
            fault_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        redirect_target = redirect_is_jalr ? ((redirect_rs1 + redirect_imm) & ~32'h1)
                                           : (redirect_pc + redirect_imm);
        // A stale response still owed by imem gates new requests until it lands.
        req      = (state_q == S_REQ) && !drop_q;
        accepted = req && imem_ready;
        pending_after = accepted ||
                        (((state_q == S_WAIT) || drop_q) && !imem_rvalid);
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        drop_d   = drop_q;
        err_d    = err_q;
        fault_d  = fault_q;

        if (redirect_valid) begin
            drop_d = pending_after;
            if (redirect_target[1]) begin
                err_d   = 1'b1;
                fault_d = redirect_target;
                state_d = S_HALT;
            end else begin
                pc_d    = redirect_target;
                err_d   = 1'b0;
                state_d = (accepted || ((state_q == S_WAIT) && !imem_rvalid)) ? S_WAIT : S_REQ;
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (drop_q) begin
                        if (imem_rvalid) drop_d = 1'b0;
                    end else if (imem_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            inst_d   = imem_rdata;
                            pc_out_d = pc_q;
                            state_d  = S_VALID;
                        end
                    end
                end
                S_VALID: begin
                    if (inst_ready) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = S_REQ;
                    end
                end
                S_HALT: begin
                    if (drop_q && imem_rvalid) drop_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Hold the presented address from acceptance until the next request.
    always_comb begin
        addr_d = (state_d == S_WAIT) ? addr_q : pc_d;
    end

    assign imem_req     = req;
    assign imem_addr    = {addr_q[31:2], 2'b00};
    assign inst_valid   = (state_q == S_VALID);
    assign inst_out     = inst_valid ? inst_q : NOP_INST;
    assign pc_out       = pc_out_q;
    assign pc_plus4_out = pc_out_q + 32'd4;
    assign misalign_err = err_q;
    assign fault_addr   = fault_q;

endmodule

// File: tb/tb_risc_fetch.sv
// Self-checking bench for risc_fetch: behavioural imem, decode scoreboard,
// and one task per scenario.
module tb_risc_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, rst;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] inst_out, pc_out, pc_plus4_out;
    logic        inst_valid, inst_ready;
    logic        redirect_valid, redirect_is_jalr;
    logic [31:0] redirect_pc, redirect_imm, redirect_rs1;
    logic        misalign_err;
    logic [31:0] fault_addr;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    int          mem_lat = 1;
    logic [31:0] dead_addr = 32'hFFFF_FFFF;

    risc_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_out(inst_out), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_is_jalr(redirect_is_jalr),
        .redirect_pc(redirect_pc), .redirect_imm(redirect_imm),
        .redirect_rs1(redirect_rs1),
        .misalign_err(misalign_err), .fault_addr(fault_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == dead_addr) ? 32'hDEAD_BEEF : {a[15:0] ^ 16'h1234, a[15:0]};
    endfunction

    // Instruction memory: one outstanding request, response mem_lat cycles after acceptance.
    initial begin : imem_model
        logic        acc, pend;
        logic [31:0] a, paddr;
        int          cnt;
        pend = 1'b0;
        cnt = 0;
        paddr = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            acc = (imem_req === 1'b1) && (imem_ready === 1'b1);
            a = imem_addr;
            #1;
            imem_rvalid = 1'b0;
            if (acc) begin
                pend = 1'b1;
                cnt = mem_lat;
                paddr = a;
            end
            if (pend) begin
                cnt--;
                if (cnt <= 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata = memf(paddr);
                    pend = 1'b0;
                end
            end
        end
    end

    // Decode-side scoreboard: every accepted instruction must match the next expected PC.
    initial begin : decode_monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && inst_valid === 1'b1) begin
                checks++;
                if (inst_out === 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL killed_word_seen inst_out=%h pc_out=%h", inst_out, pc_out);
                end
                if (inst_ready === 1'b1 && redirect_valid !== 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_accept pc_out=%h inst_out=%h", pc_out, inst_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (pc_out !== e || inst_out !== memf(e)) begin
                            errors++;
                            $display("FAIL sb_accept pc_out=%h inst_out=%h expected pc=%h inst=%h",
                                     pc_out, inst_out, e, memf(e));
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input logic [31:0] exp_pc, input string name);
        int n = 0;
        while (inst_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout inst_valid=%b expected 1", name, inst_valid);
        end else begin
            checks++;
            if (pc_out !== exp_pc || inst_out !== memf(exp_pc)) begin
                errors++;
                $display("FAIL %s pc_out=%h inst_out=%h expected pc=%h inst=%h",
                         name, pc_out, inst_out, exp_pc, memf(exp_pc));
            end
        end
    endtask

    task automatic accept(input logic [31:0] pc);
        exp_q.push_back(pc);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    task automatic do_redirect(input logic jalr, input logic [31:0] pc,
                               input logic [31:0] imm, input logic [31:0] rs1);
        redirect_valid = 1'b1;
        redirect_is_jalr = jalr;
        redirect_pc = pc;
        redirect_imm = imm;
        redirect_rs1 = rs1;
        tick();
        redirect_valid = 1'b0;
        redirect_is_jalr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0 || inst_out !== NOP) begin
            errors++;
            $display("FAIL reset_fetch req=%b addr=%h valid=%b inst=%h expected 0 0 0 %h",
                     imem_req, imem_addr, inst_valid, inst_out, NOP);
        end
        checks++;
        if (pc_out !== 32'h0 || pc_plus4_out !== 32'h4 || misalign_err !== 1'b0 || fault_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc pc=%h pc4=%h err=%b fault=%h expected 0 4 0 0",
                     pc_out, pc_plus4_out, misalign_err, fault_addr);
        end
        rst = 1'b0;
        inst_ready = 1'b1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req imem_req=%b expected 0", imem_req);
        end
    endtask

    task automatic test_sequential();
        logic        exp_req, exp_v;
        logic [31:0] exp_a, exp_pc;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            tick();
            inst_ready = (cyc < 9);
            exp_req = (cyc % 3 == 1);
            exp_a = 32'(4 * ((cyc - 1) / 3));
            exp_v = (cyc % 3 == 0);
            exp_pc = 32'(4 * (cyc / 3 - 1));
            checks++;
            if (imem_req !== exp_req || inst_valid !== exp_v) begin
                errors++;
                $display("FAIL seq_timing cyc=%0d req=%b valid=%b expected %b %b",
                         cyc, imem_req, inst_valid, exp_req, exp_v);
            end
            if (exp_req) begin
                checks++;
                if (imem_addr !== exp_a) begin
                    errors++;
                    $display("FAIL seq_addr cyc=%0d addr=%h expected %h", cyc, imem_addr, exp_a);
                end
            end
            if (exp_v) begin
                checks++;
                if (pc_out !== exp_pc || pc_plus4_out !== exp_pc + 32'd4) begin
                    errors++;
                    $display("FAIL seq_pc cyc=%0d pc=%h pc4=%h expected %h %h",
                             cyc, pc_out, pc_plus4_out, exp_pc, exp_pc + 32'd4);
                end
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (inst_valid !== 1'b1 || pc_out !== 32'h8 || inst_out !== memf(32'h8) || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold i=%0d valid=%b pc=%h inst=%h req=%b expected 1 8 %h 0",
                         i, inst_valid, pc_out, inst_out, imem_req, memf(32'h8));
            end
            tick();
        end
        accept(32'h8);
        checks++;
        if (inst_valid !== 1'b0 || inst_out !== NOP || imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            errors++;
            $display("FAIL stall_release valid=%b inst=%h req=%b addr=%h expected 0 %h 1 c",
                     inst_valid, inst_out, imem_req, imem_addr, NOP);
        end
    endtask

    task automatic test_branch();
        wait_valid(32'hC, "fetch_c");
        do_redirect(1'b0, 32'h100, 32'hFFFF_FFF0, 32'h0);
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hF0) begin
            errors++;
            $display("FAIL branch_target valid=%b req=%b addr=%h expected 0 1 f0",
                     inst_valid, imem_req, imem_addr);
        end
        wait_valid(32'hF0, "branch_fetch");
    endtask

    task automatic test_jalr();
        do_redirect(1'b1, 32'h0, 32'h4, 32'h2001);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h2004 || misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL jalr_target req=%b addr=%h err=%b expected 1 2004 0",
                     imem_req, imem_addr, misalign_err);
        end
        wait_valid(32'h2004, "jalr_fetch");
        do_redirect(1'b1, 32'h0, 32'h0, 32'h2002);
        repeat (3) begin
            checks++;
            if (misalign_err !== 1'b1 || fault_addr !== 32'h2002 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL jalr_misalign err=%b fault=%h req=%b valid=%b expected 1 2002 0 0",
                         misalign_err, fault_addr, imem_req, inst_valid);
            end
            tick();
        end
        do_redirect(1'b0, 32'h20, 32'h20, 32'h0);
        checks++;
        if (misalign_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL halt_resume err=%b req=%b addr=%h expected 0 1 40",
                     misalign_err, imem_req, imem_addr);
        end
        wait_valid(32'h40, "resume_fetch");
    endtask

    task automatic test_redirect_wait();
        dead_addr = 32'h44;
        mem_lat = 3;
        accept(32'h40);
        tick();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL wait_entry imem_req=%b expected 0", imem_req);
        end
        do_redirect(1'b0, 32'h200, 32'h100, 32'h0);
        mem_lat = 1;
        tick();
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h300 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_redirect req=%b addr=%h valid=%b expected 1 300 0",
                     imem_req, imem_addr, inst_valid);
        end
        wait_valid(32'h300, "wait_redirect_fetch");

        dead_addr = 32'h304;
        accept(32'h300);
        tick();
        do_redirect(1'b0, 32'h400, 32'h0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h400 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_redirect req=%b addr=%h valid=%b expected 1 400 0",
                     imem_req, imem_addr, inst_valid);
        end
        wait_valid(32'h400, "same_cycle_fetch");
    endtask

    task automatic test_reset_in_wait();
        dead_addr = 32'h404;
        mem_lat = 2;
        accept(32'h400);
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0 || inst_out !== NOP || pc_out !== 32'h0 ||
            pc_plus4_out !== 32'h4 || imem_addr !== 32'h0 || misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_wait valid=%b req=%b inst=%h pc=%h pc4=%h addr=%h err=%b expected reset values",
                     inst_valid, imem_req, inst_out, pc_out, pc_plus4_out, imem_addr, misalign_err);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_fetch req=%b addr=%h valid=%b expected 1 0 0",
                     imem_req, imem_addr, inst_valid);
        end
        wait_valid(32'h0, "restart_fetch");
        accept(32'h0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        imem_ready = 1'b1;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_is_jalr = 1'b0;
        redirect_pc = 32'h0;
        redirect_imm = 32'h0;
        redirect_rs1 = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jalr();
        test_redirect_wait();
        test_reset_in_wait();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover remaining=%0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
